// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART RX command parser.
// Holds the ASCII constants, the parser state and command-code enums,
// the one-hot mode encodings and the command words the matcher compares
// against. Imported by the matcher and the parser top.
package uart_cmd_pkg;

  localparam logic [7:0] LF      = 8'h0A;
  localparam logic [7:0] CR      = 8'h0D;
  localparam logic [7:0] COLON   = 8'h3A;
  localparam logic [7:0] DIGIT_0 = 8'h30;
  localparam logic [7:0] DIGIT_9 = 8'h39;

  // Longest command ("rate:D"); the matcher only needs this many bytes.
  localparam int CMD_MAX_CHARS = 6;

  // Command words, first character in the most significant byte.
  localparam logic [31:0] WORD_INIT = "init";
  localparam logic [31:0] WORD_NORM = "norm";
  localparam logic [31:0] WORD_CTRL = "ctrl";
  localparam logic [31:0] WORD_RATE = "rate";

  // Mode register bit order: {start_control, normal, initial}.
  localparam logic [2:0] MODE_INIT = 3'b001;
  localparam logic [2:0] MODE_NORM = 3'b010;
  localparam logic [2:0] MODE_CTRL = 3'b100;

  typedef enum logic [1:0] {
    ST_COLLECT,
    ST_EXEC,
    ST_DISCARD
  } parser_state_e;

  typedef enum logic [2:0] {
    CMD_NONE,
    CMD_INIT,
    CMD_NORM,
    CMD_CTRL,
    CMD_RATE,
    CMD_BAD
  } cmd_e;

endpackage

// File: rtl/uart_rx_cmd_parser_if.sv
// Byte stream from the UART RX deserializer into the command parser.
//   iRX_DATA  : received byte (source -> parser)
//   iRX_VALID : one-cycle strobe, iRX_DATA valid (source -> parser)
//   oRX_READY : parser can take a byte (parser -> source)
interface uart_rx_cmd_parser_if;
  logic [7:0] iRX_DATA;
  logic       iRX_VALID;
  logic       oRX_READY;

  modport master (output iRX_DATA, output iRX_VALID, input oRX_READY);
  modport slave  (input iRX_DATA, input iRX_VALID, output oRX_READY);
endinterface

// File: rtl/uart_cmd_match.sv
// Combinational command decoder.
//   cmd_buf    : first CMD_MAX_CHARS stored characters, index 0 first
//   len        : number of valid characters in the line buffer
//   cmd        : decoded command code (NONE for an empty buffer, BAD if no match)
//   rate_digit : the digit of a "rate:D" command
// Matching is exact length and case sensitive.
module uart_cmd_match
  import uart_cmd_pkg::*;
#(
  parameter int LEN_W = 4
) (
  input  logic [CMD_MAX_CHARS-1:0][7:0] cmd_buf,
  input  logic [LEN_W-1:0]              len,
  output cmd_e                          cmd,
  output logic [7:0]                    rate_digit
);

  logic [31:0] word4;

  always_comb begin
    word4      = {cmd_buf[0], cmd_buf[1], cmd_buf[2], cmd_buf[3]};
    rate_digit = cmd_buf[5];
    cmd        = CMD_BAD;
    if (len == '0) begin
      cmd = CMD_NONE;
    end else if (len == LEN_W'(4)) begin
      if (word4 == WORD_INIT)      cmd = CMD_INIT;
      else if (word4 == WORD_NORM) cmd = CMD_NORM;
      else if (word4 == WORD_CTRL) cmd = CMD_CTRL;
    end else if (len == LEN_W'(6)) begin
      if (word4 == WORD_RATE && cmd_buf[4] == COLON &&
          cmd_buf[5] >= DIGIT_0 && cmd_buf[5] <= DIGIT_9)
        cmd = CMD_RATE;
    end
  end

endmodule

// File: rtl/uart_rx_cmd_parser.sv
// UART RX command parser: assembles LF-terminated lines from received
// bytes, decodes them and drives the TX generator's mode levels and rate.
//   clk, reset          : clock, synchronous active-high reset
//   rx (slave)          : received byte stream with ready back-pressure
//   oMODE_*             : one-hot mode levels (initial/normal/start control)
//   oRATE               : ASCII rate digit
//   oCMD_VALID/oCMD_ERR : one-cycle accept / reject pulses
module uart_rx_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter int         MAX_LEN      = 8,
  parameter logic [7:0] RATE_DEFAULT = 8'h30
) (
  input  logic                 clk,
  input  logic                 reset,
  uart_rx_cmd_parser_if.slave  rx,
  output logic                 oMODE_INITIAL,
  output logic                 oMODE_NORMAL,
  output logic                 oMODE_START_CONTROL,
  output logic [7:0]           oRATE,
  output logic                 oCMD_VALID,
  output logic                 oCMD_ERR
);

  localparam int LEN_W = $clog2(MAX_LEN + 1);

  parser_state_e              state_q, state_d;
  logic [LEN_W-1:0]           len_q, len_d;
  logic [MAX_LEN-1:0][7:0]    cmd_buf_q, cmd_buf_d;
  logic [2:0]                 mode_q, mode_d;
  logic [7:0]                 rate_q, rate_d;
  logic                       valid_q, valid_d;
  logic                       err_q, err_d;
  logic                       ready_q, ready_d;

  logic                       accept;
  cmd_e                       cmd;
  logic [7:0]                 rate_digit;

  uart_cmd_match #(.LEN_W(LEN_W)) u_match (
    .cmd_buf    (cmd_buf_q[CMD_MAX_CHARS-1:0]),
    .len        (len_q),
    .cmd        (cmd),
    .rate_digit (rate_digit)
  );

  assign accept = rx.iRX_VALID && ready_q;

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    cmd_buf_d = cmd_buf_q;
    mode_d    = mode_q;
    rate_d    = rate_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    unique case (state_q)
      ST_COLLECT: begin
        if (accept && rx.iRX_DATA != CR) begin
          if (rx.iRX_DATA == LF) begin
            if (len_q != '0) state_d = ST_EXEC;
          end else if (len_q < LEN_W'(MAX_LEN)) begin
            // Loop write avoids indexing the buffer with the wider len counter.
            for (int i = 0; i < MAX_LEN; i++)
              if (len_q == LEN_W'(i)) cmd_buf_d[i] = rx.iRX_DATA;
            len_d = len_q + LEN_W'(1);
          end else begin
            state_d = ST_DISCARD;
          end
        end
      end
      ST_DISCARD: begin
        if (accept && rx.iRX_DATA == LF) begin
          err_d   = 1'b1;
          len_d   = '0;
          state_d = ST_COLLECT;
        end
      end
      ST_EXEC: begin
        valid_d = 1'b1;
        unique case (cmd)
          CMD_INIT: mode_d = MODE_INIT;
          CMD_NORM: mode_d = MODE_NORM;
          CMD_CTRL: mode_d = MODE_CTRL;
          CMD_RATE: rate_d = rate_digit;
          default: begin
            valid_d = 1'b0;
            err_d   = 1'b1;
          end
        endcase
        len_d   = '0;
        state_d = ST_COLLECT;
      end
      default: state_d = ST_COLLECT;
    endcase
    // Ready is registered so it is already low during the EXEC cycle.
    ready_d = (state_d != ST_EXEC);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_COLLECT;
      len_q     <= '0;
      cmd_buf_q <= '0;
      mode_q    <= MODE_INIT;
      rate_q    <= RATE_DEFAULT;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      cmd_buf_q <= cmd_buf_d;
      mode_q    <= mode_d;
      rate_q    <= rate_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      ready_q   <= ready_d;
    end
  end

  assign rx.oRX_READY          = ready_q;
  assign oMODE_INITIAL         = mode_q[0];
  assign oMODE_NORMAL          = mode_q[1];
  assign oMODE_START_CONTROL   = mode_q[2];
  assign oRATE                 = rate_q;
  assign oCMD_VALID            = valid_q;
  assign oCMD_ERR              = err_q;

endmodule

// File: tb/tb_uart_rx_cmd_parser.sv
// Directed testbench for uart_rx_cmd_parser: sends command lines byte by
// byte, checks latency, mode/rate updates and pulse counts.
module tb_uart_rx_cmd_parser;

  logic       clk;
  logic       reset;
  logic       oMODE_INITIAL, oMODE_NORMAL, oMODE_START_CONTROL;
  logic [7:0] oRATE;
  logic       oCMD_VALID, oCMD_ERR;

  uart_rx_cmd_parser_if rxIf ();

  uart_rx_cmd_parser dut (
    .clk                 (clk),
    .reset               (reset),
    .rx                  (rxIf.slave),
    .oMODE_INITIAL       (oMODE_INITIAL),
    .oMODE_NORMAL        (oMODE_NORMAL),
    .oMODE_START_CONTROL (oMODE_START_CONTROL),
    .oRATE               (oRATE),
    .oCMD_VALID          (oCMD_VALID),
    .oCMD_ERR            (oCMD_ERR)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int testsRun    = 0;
  int testsFailed = 0;

  // Pulse and invariant counters, written only by the monitor below.
  int validCount = 0;
  int errCount   = 0;
  int oneHotBad  = 0;
  int bothBad    = 0;
  int validBase, errBase;

  always @(negedge clk) begin
    if (!reset) begin
      if (oCMD_VALID) validCount++;
      if (oCMD_ERR) errCount++;
      if ({2'b0, oMODE_INITIAL} + {2'b0, oMODE_NORMAL} + {2'b0, oMODE_START_CONTROL} != 3'd1)
        oneHotBad++;
      if (oCMD_VALID && oCMD_ERR) bothBad++;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // One byte, valid for exactly one rising edge; returns at the following negedge.
  task automatic applyStimulus(input logic [7:0] b);
    @(negedge clk);
    rxIf.iRX_DATA  = b;
    rxIf.iRX_VALID = 1'b1;
    @(negedge clk);
    rxIf.iRX_VALID = 1'b0;
  endtask

  task automatic sendString(input string s);
    for (int i = 0; i < s.len(); i++) applyStimulus(s[i]);
  endtask

  task automatic settle();
    repeat (3) @(negedge clk);
    #1;
  endtask

  task automatic snapshot();
    validBase = validCount;
    errBase   = errCount;
  endtask

  function automatic logic [2:0] modes();
    return {oMODE_START_CONTROL, oMODE_NORMAL, oMODE_INITIAL};
  endfunction

  initial begin
    reset          = 1'b1;
    rxIf.iRX_DATA  = 8'h00;
    rxIf.iRX_VALID = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    $display("[TB] reset state");
    checkOutput("rst modes", modes(), 3'b001);
    checkOutput("rst rate", oRATE, 8'h30);
    checkOutput("rst valid", oCMD_VALID, 1'b0);
    checkOutput("rst err", oCMD_ERR, 1'b0);
    checkOutput("rst ready", rxIf.oRX_READY, 1'b1);

    // Test 1: rate:7 with exact latency
    snapshot();
    sendString("rate:7");
    applyStimulus(8'h0A);
    #1;
    checkOutput("t1 exec ready low", rxIf.oRX_READY, 1'b0);
    checkOutput("t1 no early pulse", oCMD_VALID, 1'b0);
    @(negedge clk); #1;
    checkOutput("t1 valid pulse", oCMD_VALID, 1'b1);
    checkOutput("t1 rate", oRATE, 8'h37);
    checkOutput("t1 modes", modes(), 3'b001);
    @(negedge clk); #1;
    checkOutput("t1 pulse one cycle", oCMD_VALID, 1'b0);
    settle();
    checkOutput("t1 valid count", validCount - validBase, 1);
    checkOutput("t1 err count", errCount - errBase, 0);

    // Test 2: norm with CR, then ctrl
    snapshot();
    sendString("norm");
    applyStimulus(8'h0D);
    applyStimulus(8'h0A);
    settle();
    checkOutput("t2 norm modes", modes(), 3'b010);
    sendString("ctrl");
    applyStimulus(8'h0A);
    settle();
    checkOutput("t2 ctrl modes", modes(), 3'b100);
    checkOutput("t2 valid count", validCount - validBase, 2);
    checkOutput("t2 err count", errCount - errBase, 0);

    // Test 3: three rejected lines
    snapshot();
    sendString("rate:x"); applyStimulus(8'h0A);
    sendString("INIT");   applyStimulus(8'h0A);
    sendString("ini");    applyStimulus(8'h0A);
    settle();
    checkOutput("t3 err count", errCount - errBase, 3);
    checkOutput("t3 valid count", validCount - validBase, 0);
    checkOutput("t3 rate", oRATE, 8'h37);
    checkOutput("t3 modes", modes(), 3'b100);

    // Test 4: overflow line, then a good line
    snapshot();
    for (int i = 0; i < 12; i++) applyStimulus("a");
    applyStimulus(8'h0A);
    settle();
    checkOutput("t4 overflow err", errCount - errBase, 1);
    sendString("init"); applyStimulus(8'h0A);
    settle();
    checkOutput("t4 modes", modes(), 3'b001);
    checkOutput("t4 valid count", validCount - validBase, 1);
    checkOutput("t4 err count", errCount - errBase, 1);

    // Test 5: empty lines
    snapshot();
    applyStimulus(8'h0A);
    applyStimulus(8'h0D);
    applyStimulus(8'h0A);
    settle();
    checkOutput("t5 valid count", validCount - validBase, 0);
    checkOutput("t5 err count", errCount - errBase, 0);
    checkOutput("t5 modes", modes(), 3'b001);
    checkOutput("t5 rate", oRATE, 8'h37);

    // Test 6: reset mid-line, then a byte strobed during EXEC
    sendString("rat");
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    #1;
    checkOutput("t6 rate after reset", oRATE, 8'h30);
    checkOutput("t6 modes after reset", modes(), 3'b001);
    snapshot();
    sendString("e:5"); applyStimulus(8'h0A);
    settle();
    checkOutput("t6 partial err", errCount - errBase, 1);
    checkOutput("t6 rate kept", oRATE, 8'h30);
    sendString("rate:9");
    @(negedge clk);
    rxIf.iRX_DATA  = 8'h0A;
    rxIf.iRX_VALID = 1'b1;
    @(negedge clk);
    checkOutput("t6 ready low in exec", rxIf.oRX_READY, 1'b0);
    rxIf.iRX_DATA = "z";
    @(negedge clk);
    rxIf.iRX_VALID = 1'b0;
    #1;
    checkOutput("t6 rate 9", oRATE, 8'h39);
    sendString("norm"); applyStimulus(8'h0A);
    settle();
    checkOutput("t6 dropped byte", modes(), 3'b010);
    checkOutput("t6 valid count", validCount - validBase, 2);
    checkOutput("t6 err count", errCount - errBase, 1);

    checkOutput("one-hot modes", oneHotBad, 0);
    checkOutput("exclusive pulses", bothBad, 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
